gauss_skew_feeder: RTL
======================

Name: gauss_skew_feeder

Overview:
- Upstream feeder for the systolic Gaussian-elimination / multiply array of processor_AB-style cells.
- Accepts full matrix rows over a valid/ready interface and emits them column-skewed: lane k is delayed by k cycles.
- Frames each job with a per-lane start flag on the first row and a trailing finish beat.
- Holds the job opcode stable for the whole job and signals completion once the finish beat has left the last lane.

Parameters:
- GF_BIT, 4, field element width (4 = GF(16), 8 = GF(256)).
- N, 8, number of array columns (lanes), N >= 2.
- OP_CODE_LEN, 4, opcode width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- job_start  in  1  one-cycle pulse that opens a job; honoured only in IDLE.
- job_op  in  OP_CODE_LEN  opcode, sampled on an honoured job_start.
- in_valid  in  1  row available.
- in_ready  out  1  feeder accepts a row.
- in_row  in  N*GF_BIT  row; element k is bits [k*GF_BIT +: GF_BIT].
- in_last  in  1  marks the final row of the job.
- out_data  out  N*GF_BIT  skewed lane data; lane k uses the same bit slice as the input.
- out_valid  out  N  per-lane beat valid.
- out_start  out  N  per-lane start flag (first row of the job).
- out_finish  out  N  per-lane finish flag.
- out_op  out  OP_CODE_LEN  job opcode.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, immediate): state IDLE; all skew stages cleared; out_data = 0; out_valid, out_start and out_finish all 0; out_op = 0; in_ready = 0; busy = 0; done = 0.
- Reset mid-job aborts the job. No finish beat and no done pulse are produced.
- States: IDLE, LOAD, FIN, DRAIN.
- IDLE -> LOAD on job_start:
  - latches job_op into out_op;
  - sets start_pending = 1.
- LOAD:
  - in_ready = 1.
  - An accept (in_valid & in_ready) injects a beat into the skew head: valid = 1, start = start_pending, finish = 0, data = in_row. start_pending is then cleared.
  - A cycle with no accept injects a bubble: valid = 0, data = 0, start = 0, finish = 0. start_pending is unchanged.
  - Accept with in_last -> FIN.
- FIN (one cycle):
  - in_ready = 0.
  - Injects the finish beat: valid = 1, finish = 1, start = 0, data = 0.
  - -> DRAIN with the drain counter = 0.
- DRAIN:
  - in_ready = 0; bubbles are injected.
  - The counter increments each cycle.
  - While lane N-1 shows finish: done = 1 and the next state is IDLE.
- Skew structure: lane k is a register chain of length k+1. A beat injected at clock edge t appears on lane k during the cycle after edge t+k, i.e. lane 0 is one cycle after the accept edge and lane k is k+1 cycles after it.
- Timing: last accept at edge L -> lane k shows finish k+2 cycles after L -> done asserted N+1 cycles after L.
- out_op:
  - holds from an honoured job_start until the next honoured job_start;
  - is not cleared in IDLE;
  - is cleared only by rst.
- job_start outside IDLE is ignored: out_op and the state are unchanged.
- Single-row job (in_last on the first accept): the start beat and the finish beat are separate consecutive beats.
- in_last is only meaningful with an accept; in_last without in_valid has no effect.
- The skew chain shifts every cycle, including in IDLE, where it shifts bubbles so residual beats drain.
- busy = (state != IDLE).
- No combinational path from input to output except in_ready, which is a function of state only.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately; in_ready = 0; busy = 0.
- N=4, GF_BIT=4, job_op = 7:
  - stimulus: rows 0x4321, 0x8765, 0xCBA9 accepted back-to-back at edges 0, 1, 2, last on 0xCBA9;
  - lane 0 shows 1, 5, 9 during cycles 1, 2, 3;
  - lane 3 shows 4, 8, C during cycles 4, 5, 6;
  - out_start is set only on the first beat of each lane (lane 0 cycle 1, lane 3 cycle 4);
  - finish shows on lane 0 in cycle 4 and on lane 3 in cycle 7;
  - done pulses in cycle 7; out_op = 7 throughout.
- Bubble: as above, but in_valid low at edge 1 -> every lane k has out_valid = 0 and data = 0 in cycle 2+k. The second row is shifted one cycle later and done slips by 1.
- Start latched across a bubble: after job_start, in_valid stays low for 3 cycles and then a row is accepted -> out_start = 1 on that row's beat only, never on the bubbles.
- Single-row job with last = 1 -> per lane, start beat then finish beat on consecutive cycles; done 5 cycles after the accept (N=4).
- job_start with job_op = 3 while busy -> ignored; out_op stays 7.
- rst during DRAIN -> lanes cleared, no done pulse, IDLE; a new job then runs cleanly.

Source files
------------

// File: rtl/gauss_skew_feeder.sv
// Row-to-column-skew feeder for the systolic Gaussian-elimination array.
// Lane k delays every beat by k+1 cycles; jobs are framed by start/finish flags.
module gauss_skew_lane #(
  parameter int GF_BIT = 4,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              head_vld,
  input  logic              head_start,
  input  logic              head_fin,
  input  logic [GF_BIT-1:0] head_data,
  output logic              lane_vld,
  output logic              lane_start,
  output logic              lane_fin,
  output logic [GF_BIT-1:0] lane_data
);
  typedef struct packed {
    logic              vld;
    logic              start;
    logic              fin;
    logic [GF_BIT-1:0] data;
  } beat_t;

  beat_t [DEPTH-1:0] beat_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_pipe <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) beat_pipe[i] <= beat_pipe[i-1];
      beat_pipe[0] <= '{vld: head_vld, start: head_start, fin: head_fin, data: head_data};
    end
  end

  assign lane_vld   = beat_pipe[DEPTH-1].vld;
  assign lane_start = beat_pipe[DEPTH-1].start;
  assign lane_fin   = beat_pipe[DEPTH-1].fin;
  assign lane_data  = beat_pipe[DEPTH-1].data;
endmodule

module gauss_skew_feeder #(
  parameter int GF_BIT      = 4,
  parameter int N           = 8,
  parameter int OP_CODE_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_start,
  input  logic [OP_CODE_LEN-1:0] job_op,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*GF_BIT-1:0]    in_row,
  input  logic                   in_last,
  output logic [N*GF_BIT-1:0]    out_data,
  output logic [N-1:0]           out_valid,
  output logic [N-1:0]           out_start,
  output logic [N-1:0]           out_finish,
  output logic [OP_CODE_LEN-1:0] out_op,
  output logic                   busy,
  output logic                   done
);
  localparam int CNT_W = $clog2(N + 1) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, FIN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic             start_pending;
  logic [CNT_W-1:0] drain_cnt;
  logic             accept;
  logic             head_vld, head_start, head_fin, head_gate;

  assign in_ready = (state_q == LOAD);
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DRAIN) & out_finish[N-1];

  always_comb begin
    state_d    = state_q;
    head_vld   = 1'b0;
    head_start = 1'b0;
    head_fin   = 1'b0;
    head_gate  = 1'b0;
    case (state_q)
      IDLE:  if (job_start) state_d = LOAD;
      LOAD: begin
        if (accept) begin
          head_vld   = 1'b1;
          head_start = start_pending;
          head_gate  = 1'b1;
          if (in_last) state_d = FIN;
        end
      end
      FIN: begin
        // Finish travels as its own beat, never merged with the last row.
        head_vld = 1'b1;
        head_fin = 1'b1;
        state_d  = DRAIN;
      end
      DRAIN: if (out_finish[N-1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      start_pending <= 1'b0;
      out_op        <= '0;
      drain_cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && job_start) begin
        out_op        <= job_op;
        start_pending <= 1'b1;
      end else if (accept) begin
        start_pending <= 1'b0;
      end
      if (state_q == FIN)        drain_cnt <= '0;
      else if (state_q == DRAIN) drain_cnt <= drain_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    gauss_skew_lane #(.GF_BIT(GF_BIT), .DEPTH(k + 1)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .head_vld   (head_vld),
      .head_start (head_start),
      .head_fin   (head_fin),
      .head_data  (head_gate ? in_row[k*GF_BIT +: GF_BIT] : '0),
      .lane_vld   (out_valid[k]),
      .lane_start (out_start[k]),
      .lane_fin   (out_finish[k]),
      .lane_data  (out_data[k*GF_BIT +: GF_BIT])
    );
  end
endmodule
